// File: rtl/z3_pkg.sv
// Shared types and constants for the Zorro III cycle initiator.
package z3_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAssert,
    StStrobe,
    StRelease,
    StRecover
  } z3_state_e;

  localparam logic [3:0] DS_IDLE = 4'hF;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/z3_cycle_initiator_if.sv
// Request/response and Zorro III bus signals of the cycle initiator.
// The master modport is the initiator's view; slave is the host/target side.
interface z3_cycle_initiator_if;
  logic        req;
  logic        req_read;
  logic [29:0] req_addr;
  logic [3:0]  req_ds_n;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        berr;
  logic [31:0] rdata;
  logic [29:0] A;
  logic        FCS_n;
  logic [3:0]  DS_n;
  logic        READ;
  logic        DOE;
  logic [31:0] D_out;
  logic        D_oe;
  logic [31:0] D_in;
  logic        DTACK_n;
  logic        BERR_n;
  logic        SLAVE_n;

  modport master (
    input  req, req_read, req_addr, req_ds_n, req_wdata, D_in, DTACK_n, BERR_n, SLAVE_n,
    output busy, done, berr, rdata, A, FCS_n, DS_n, READ, DOE, D_out, D_oe
  );

  modport slave (
    output req, req_read, req_addr, req_ds_n, req_wdata, D_in, DTACK_n, BERR_n, SLAVE_n,
    input  busy, done, berr, rdata, A, FCS_n, DS_n, READ, DOE, D_out, D_oe
  );
endinterface

// File: rtl/z3_timeout_counter.sv
// STROBE-phase watchdog; the module exists only when Z3_TIMEOUT_EN is defined.
`ifdef Z3_TIMEOUT_EN
module z3_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = z3_pkg::TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  // Cleared on the entry edge, so the first STROBE cycle sees zero and the
  // TIMEOUT_CYCLES-th STROBE cycle raises expired.
  assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/z3_cycle_initiator.sv
// Zorro III bus master: runs one full cycle per accepted request.
// Define Z3_TIMEOUT_EN to abort STROBE after TIMEOUT_CYCLES without a response.
module z3_cycle_initiator
  import z3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned DS_SETUP       = 1
) (
  input logic                  clk,
  input logic                  rst,
  z3_cycle_initiator_if.master bus
);
  localparam int unsigned SetupW = $clog2(DS_SETUP + 1);

  if (DS_SETUP == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("DS_SETUP and TIMEOUT_CYCLES must both be at least 1");
  end

  z3_state_e         state_q, state_d;
  logic [SetupW-1:0] setup_q;
  logic [29:0]       addr_q;
  logic [3:0]        ds_q;
  logic [31:0]       wdata_q;
  logic              read_q;
  logic              berr_q;
  logic [31:0]       rdata_q;

  logic in_strobe;
  logic setup_done;
  logic timeout_hit;
  logic end_ok;
  logic end_err;

  assign in_strobe  = (state_q == StStrobe);
  assign setup_done = (setup_q == SetupW'(DS_SETUP - 1));

`ifdef Z3_TIMEOUT_EN
  logic strobe_entry;
  assign strobe_entry = (state_d == StStrobe) && !in_strobe;

  z3_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (strobe_entry),
    .enable (in_strobe),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    end_ok  = 1'b0;
    end_err = 1'b0;
    unique case (state_q)
      StIdle:   if (bus.req) state_d = StAddr;
      StAddr:   state_d = StAssert;
      StAssert: if (setup_done) state_d = StStrobe;
      StStrobe: begin
        // Bus error beats acknowledge; an acknowledge beats the watchdog.
        if (!bus.BERR_n) begin
          end_err = 1'b1;
        end else if (!bus.DTACK_n) begin
          end_ok = 1'b1;
        end else if (timeout_hit) begin
          end_err = 1'b1;
        end
        if (end_ok || end_err) state_d = StRelease;
      end
      StRelease: state_d = StRecover;
      StRecover: if (bus.DTACK_n && bus.SLAVE_n) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      setup_q <= '0;
      addr_q  <= '0;
      ds_q    <= DS_IDLE;
      wdata_q <= '0;
      read_q  <= 1'b1;
      berr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.req) begin
        addr_q  <= bus.req_addr;
        ds_q    <= bus.req_ds_n;
        wdata_q <= bus.req_wdata;
        read_q  <= bus.req_read;
        berr_q  <= 1'b0;
      end
      if (state_q == StAddr) begin
        setup_q <= '0;
      end else if (state_q == StAssert) begin
        setup_q <= setup_q + 1'b1;
      end
      if (end_ok) begin
        berr_q <= 1'b0;
        if (read_q) rdata_q <= bus.D_in;
      end
      if (end_err) berr_q <= 1'b1;
    end
  end

  // Bus outputs decode straight from the state register so an asynchronous
  // reset releases the bus without waiting for a clock edge.
  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StRelease);
  assign bus.berr  = berr_q;
  assign bus.rdata = rdata_q;
  assign bus.A     = addr_q;
  assign bus.READ  = read_q;
  assign bus.D_out = wdata_q;
  assign bus.FCS_n = !((state_q == StAssert) || in_strobe);
  assign bus.DS_n  = in_strobe ? ds_q : DS_IDLE;
  assign bus.DOE   = in_strobe;
  assign bus.D_oe  = in_strobe && !read_q;

endmodule

// File: tb/tb_z3_cycle_initiator.sv
// Directed bench for z3_cycle_initiator; follows Z3_TIMEOUT_EN like the DUT.
module tb_z3_cycle_initiator;
  import z3_pkg::*;

  localparam int unsigned DsSetup = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  z3_cycle_initiator_if bus ();

  z3_cycle_initiator #(
    .TIMEOUT_CYCLES(TIMEOUT_DEFAULT),
    .DS_SETUP      (DsSetup)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lat;
  int seen;

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.req_read = 1'b1; bus.req_addr = '0; bus.req_ds_n = 4'hF;
    bus.req_wdata = '0; bus.D_in = '0;
    bus.DTACK_n = 1'b1; bus.BERR_n = 1'b1; bus.SLAVE_n = 1'b1;
    tick(); tick();
    check("rst_fcs", bus.FCS_n, 1);
    check("rst_ds", bus.DS_n, 4'hF);
    check("rst_doe", bus.DOE, 0);
    check("rst_d_oe", bus.D_oe, 0);
    check("rst_read", bus.READ, 1);
    check("rst_a", bus.A, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_berr", bus.berr, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    tick();

    // Read of 0x0080_0040, target acknowledges on the third STROBE cycle
    bus.req = 1'b1; bus.req_read = 1'b1; bus.req_addr = 30'h0020_0010; bus.req_ds_n = 4'h0;
    tick();
    bus.req = 1'b0;
    check("rd_addr_busy", bus.busy, 1);
    check("rd_addr_fcs", bus.FCS_n, 1);
    check("rd_addr_a", bus.A, 30'h0020_0010);
    check("rd_addr_read", bus.READ, 1);
    tick();
    check("rd_assert_fcs", bus.FCS_n, 0);
    check("rd_assert_doe", bus.DOE, 0);
    check("rd_assert_ds", bus.DS_n, 4'hF);
    tick();
    check("rd_strobe_doe", bus.DOE, 1);
    check("rd_strobe_ds", bus.DS_n, 4'h0);
    check("rd_strobe_d_oe", bus.D_oe, 0);
    tick(); tick();
    check("rd_wait_done", bus.done, 0);
    check("rd_wait_doe", bus.DOE, 1);
    bus.DTACK_n = 1'b0; bus.SLAVE_n = 1'b0; bus.D_in = 32'hDEAD_BEEF;
    tick();
    check("rd_done", bus.done, 1);
    check("rd_berr", bus.berr, 0);
    check("rd_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("rd_rel_fcs", bus.FCS_n, 1);
    check("rd_rel_ds", bus.DS_n, 4'hF);
    check("rd_rel_doe", bus.DOE, 0);
    check("rd_rel_a", bus.A, 30'h0020_0010);
    bus.DTACK_n = 1'b1; bus.SLAVE_n = 1'b1; bus.D_in = '0;
    tick();
    check("rd_recover_done", bus.done, 0);
    check("rd_recover_busy", bus.busy, 1);
    tick();
    check("rd_idle_busy", bus.busy, 0);

    // Write with DTACK already low on STROBE entry: minimum latency path
    bus.req = 1'b1; bus.req_read = 1'b0; bus.req_addr = 30'h048D_159E;
    bus.req_ds_n = 4'hE; bus.req_wdata = 32'h1234_5678;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      bus.req = 1'b0;
      if (i >= 2) begin
        bus.DTACK_n = 1'b0; bus.SLAVE_n = 1'b0;
      end
      check("wr_d_oe", bus.D_oe, (i == 2 + DsSetup) ? 1 : 0);
      check("wr_ds", bus.DS_n, (i == 2 + DsSetup) ? 32'hE : 32'hF);
      check("wr_dout", bus.D_out, 32'h1234_5678);
      check("wr_read", bus.READ, 0);
      if (bus.done) begin
        lat = i;
        check("wr_berr", bus.berr, 0);
      end
    end
    check("wr_latency", lat, 3 + DsSetup);
    check("wr_rdata_kept", bus.rdata, 32'hDEAD_BEEF);
    bus.DTACK_n = 1'b1; bus.SLAVE_n = 1'b1;
    tick(); tick();
    check("wr_idle_busy", bus.busy, 0);

    // BERR and DTACK on the same edge
    bus.req = 1'b1; bus.req_read = 1'b1; bus.req_addr = 30'h0000_0100; bus.req_ds_n = 4'h3;
    tick();
    bus.req = 1'b0;
    tick(); tick();
    check("be_strobe_ds", bus.DS_n, 4'h3);
    bus.BERR_n = 1'b0; bus.DTACK_n = 1'b0; bus.D_in = 32'hCAFE_F00D;
    tick();
    check("be_done", bus.done, 1);
    check("be_berr", bus.berr, 1);
    check("be_rdata_kept", bus.rdata, 32'hDEAD_BEEF);
    bus.BERR_n = 1'b1; bus.DTACK_n = 1'b1;
    tick(); tick();
    check("be_idle_busy", bus.busy, 0);

    // DTACK held after RELEASE keeps RECOVER; a pending req waits
    bus.req = 1'b1; bus.req_read = 1'b1; bus.req_addr = 30'h0000_0200; bus.req_ds_n = 4'h0;
    tick();
    bus.req = 1'b0;
    tick(); tick();
    bus.DTACK_n = 1'b0; bus.SLAVE_n = 1'b0; bus.D_in = 32'h0BAD_F00D;
    tick();
    check("rc_done", bus.done, 1);
    check("rc_berr", bus.berr, 0);
    check("rc_rdata", bus.rdata, 32'h0BAD_F00D);
    bus.req = 1'b1; bus.req_addr = 30'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rc_hold_busy", bus.busy, 1);
      check("rc_hold_fcs", bus.FCS_n, 1);
      check("rc_hold_done", bus.done, 0);
      check("rc_hold_a", bus.A, 30'h0000_0200);
    end
    bus.DTACK_n = 1'b1;
    tick();
    check("rc_slave_busy", bus.busy, 1);
    check("rc_slave_a", bus.A, 30'h0000_0200);
    bus.SLAVE_n = 1'b1;
    tick();
    check("rc_idle_busy", bus.busy, 0);
    tick();
    check("rc_accept_busy", bus.busy, 1);
    check("rc_accept_a", bus.A, 30'h0000_0300);
    bus.req = 1'b0;
    tick(); tick();
    check("rs_strobe_doe", bus.DOE, 1);

    // Asynchronous reset in STROBE releases the bus before the next edge
    rst = 1'b1;
    #1;
    check("rs_fcs", bus.FCS_n, 1);
    check("rs_ds", bus.DS_n, 4'hF);
    check("rs_doe", bus.DOE, 0);
    check("rs_d_oe", bus.D_oe, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_done", bus.done, 0);
    check("rs_rdata", bus.rdata, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) seen++;
    end
    check("rs_no_done", seen, 0);
    check("rs_idle_busy", bus.busy, 0);

    // No response at all
    bus.req = 1'b1; bus.req_read = 1'b1; bus.req_addr = 30'h0000_0010; bus.req_ds_n = 4'h0;
    tick();
    bus.req = 1'b0;
    tick(); tick();
    check("to_strobe_doe", bus.DOE, 1);
`ifdef Z3_TIMEOUT_EN
    lat = 0;
    for (int i = 1; i <= int'(TIMEOUT_DEFAULT) + 10 && lat == 0; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        check("to_berr", bus.berr, 1);
      end
    end
    check("to_latency", lat, TIMEOUT_DEFAULT);
    tick(); tick();
    check("to_idle_busy", bus.busy, 0);
`else
    seen = 0;
    for (int i = 0; i < int'(TIMEOUT_DEFAULT) + 16; i++) begin
      tick();
      if (bus.done) seen++;
    end
    check("nto_no_done", seen, 0);
    check("nto_busy", bus.busy, 1);
    check("nto_doe", bus.DOE, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("nto_idle_busy", bus.busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z3_cycle_initiator.md
Z3_CYCLE_INITIATOR -- requirements
Module: z3_cycle_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: clk cycles in STROBE before a self-abort.
REQ-002 SHALL have parameter DS_SETUP, default 1: clk cycles between FCS_n falling and DS_n/DOE assertion.
REQ-003 SHALL have one clock and an asynchronous, active-high reset. Ports, clock and reset first:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start a cycle; sampled only in IDLE.
- req_read  in  1  1 = read, 0 = write.
- req_addr  in  30  longword address [31:2].
- req_ds_n  in  4  byte lanes, active-low.
- req_wdata  in  32  write data.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse at cycle end.
- berr  out  1  valid with done; 1 = bus error or timeout.
- rdata  out  32  captured read data; valid with done.
- A  out  30  Zorro address.
- FCS_n  out  1  Zorro full cycle strobe.
- DS_n  out  4  Zorro data strobes.
- READ  out  1  Zorro direction.
- DOE  out  1  data output enable.
- D_out  out  32  write data.
- D_oe  out  1  enable for driving D_out.
- D_in  in  32  bus data.
- DTACK_n  in  1  target acknowledge.
- BERR_n  in  1  bus error.
- SLAVE_n  in  1  target claims the cycle.

Function
REQ-004 SHALL run states IDLE, ADDR, ASSERT, STROBE, RELEASE, RECOVER.
REQ-005 SHALL move IDLE->ADDR on req; latch addr/ds/wdata/read; A and READ valid; FCS_n=1 for exactly 1 cycle.
REQ-006 SHALL in ASSERT drive FCS_n=0 for DS_SETUP cycles, then go to STROBE.
REQ-007 SHALL in STROBE drive DOE=1 and DS_n=latched lanes; drive D_oe=1 on writes only.
REQ-008 SHALL in STROBE: on sampled BERR_n=0, go to RELEASE with berr=1; else on DTACK_n=0, capture D_in into rdata on reads and go to RELEASE with berr=0. BERR wins when both are asserted together.
REQ-009 SHALL in RELEASE drive FCS_n=1, DS_n=4'hF, DOE=0, D_oe=0; pulse done for 1 cycle; go to RECOVER.
REQ-010 SHALL in RECOVER hold until DTACK_n=1 and SLAVE_n=1, then go to IDLE; req is ignored until then.
REQ-011 SHALL keep A, READ and D_out stable from ADDR through RELEASE.
REQ-012 SHALL hold rdata until the next successful read; writes and errors do not change it.
REQ-013 SHALL give minimum latency req->done of 3+DS_SETUP cycles when DTACK_n is already low on STROBE entry.

Reset
REQ-014 SHALL force, on rst: IDLE, FCS_n=1, DS_n=4'hF, DOE=0, D_oe=0, READ=1, A=0, busy=0, done=0, berr=0, rdata=0.
REQ-015 SHALL release the bus within the same reset assertion if rst arrives mid-cycle, with no done pulse.

Configuration
REQ-016 SHALL, with Z3_TIMEOUT_EN defined, count cycles in STROBE; at TIMEOUT_CYCLES without DTACK/BERR, go to RELEASE with berr=1.
REQ-017 SHALL, without Z3_TIMEOUT_EN, remove the counter; STROBE waits indefinitely.

Structure
REQ-018 SHALL keep the state enum, DS_IDLE=4'hF and the default timeout in shared package z3_pkg.
REQ-019 SHALL use sub-module z3_timeout_counter (clear on STROBE entry, expire flag), present only under Z3_TIMEOUT_EN.

Verification
REQ-020 Read: addr 0x0080_0040, lanes 4'h0, target DTACK after 3 cycles with D_in=0xDEADBEEF -> rdata=0xDEADBEEF, berr=0, done once.
REQ-021 Write: 0x1234_5678 to lanes 4'hE -> D_oe=1 only in STROBE, D_out stable, DS_n=4'hE, done with berr=0.
REQ-022 BERR_n and DTACK_n low on the same edge -> berr=1, rdata unchanged.
REQ-023 Z3_TIMEOUT_EN, no response -> done with berr=1 exactly 64 cycles after STROBE entry; without the macro, busy stays high.
REQ-024 rst pulse in STROBE -> FCS_n=1, DS_n=4'hF, DOE=0 before the next edge; no done.
REQ-025 DTACK_n held low after RELEASE -> stays in RECOVER; req ignored until DTACK_n=1 and SLAVE_n=1.
